hc595_chain_ctrl: RTL and testbench



---
 rtl/hc595_chain_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hc595_chain_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_chain_ctrl.sv
// hc595_chain_ctrl: serial driver for a daisy-chain of 74HC595 shift registers.
// Accepts a CHAIN_BITS frame over valid/ready into a 1-deep pending buffer,
// shifts it out on ds/shcp (CLK_DIV cycles per bit slot), then pulses stcp.
// Optional auto-refresh resends the last frame when nothing is pending.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   din, din_valid, din_ready frame input handshake (din_ready = pending empty)
//   auto_refresh              repeat current frame when nothing is pending
//   oe_en                     output-enable request
//   stcp, shcp, ds            595 latch clock, shift clock, serial data
//   oe                        active-low 595 output enable
//   busy                      frame in progress (shift or latch)
//   frame_done                one-cycle pulse after each latch completes
module hc595_chain_ctrl #(
  parameter int unsigned CHAIN_BITS = 14,
  parameter int unsigned CLK_DIV    = 4,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CHAIN_BITS-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  auto_refresh,
  input  logic                  oe_en,
  output logic                  stcp,
  output logic                  shcp,
  output logic                  ds,
  output logic                  oe,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned SLOT_W = $clog2(CHAIN_BITS + 1);
  localparam int unsigned PH_W   = $clog2(CLK_DIV);

  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HALF    = PH_W'(CLK_DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_LASTB = SLOT_W'(CHAIN_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LATCH = SLOT_W'(CHAIN_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                state;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [PH_W-1:0]       phase_cnt;
  logic [CHAIN_BITS-1:0] shadow;
  logic [CHAIN_BITS-1:0] pend;
  logic                  pend_valid;
  logic                  latched_once;

  state_t                nxt_state;
  logic [SLOT_W-1:0]     nxt_slot;
  logic [PH_W-1:0]       nxt_phase;
  logic [CHAIN_BITS-1:0] nxt_shadow;
  logic                  nxt_pend_valid;
  logic                  load_pend;
  logic                  frame_end;
  logic                  accept;
  logic [SLOT_W-1:0]     bit_idx;
  logic                  nxt_ds;

  assign accept = din_valid & din_ready;

  // Next-state / counter logic; outputs are registered from these next values
  // so every pin reflects the slot/phase of the cycle it is driven in.
  always_comb begin
    nxt_state  = state;
    nxt_slot   = slot_cnt;
    nxt_phase  = phase_cnt;
    load_pend  = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          load_pend = 1'b1;
          nxt_state = ST_SHIFT;
          nxt_slot  = '0;
          nxt_phase = '0;
        end
      end
      ST_SHIFT: begin
        if (phase_cnt == PH_LAST) begin
          nxt_phase = '0;
          if (slot_cnt == SLOT_LASTB) begin
            nxt_state = ST_LATCH;
            nxt_slot  = SLOT_LATCH;
          end else begin
            nxt_slot = slot_cnt + SLOT_W'(1);
          end
        end else begin
          nxt_phase = phase_cnt + PH_W'(1);
        end
      end
      ST_LATCH: begin
        if (phase_cnt == PH_LAST) begin
          frame_end = 1'b1;
          nxt_phase = '0;
          nxt_slot  = '0;
          if (pend_valid) begin
            load_pend = 1'b1;
            nxt_state = ST_SHIFT;
          end else if (auto_refresh) begin
            nxt_state = ST_SHIFT;
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_phase = phase_cnt + PH_W'(1);
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_slot  = '0;
        nxt_phase = '0;
      end
    endcase
  end

  // Pending buffer empties on load; accept only possible while it is empty.
  assign nxt_pend_valid = accept | (pend_valid & ~load_pend);
  assign nxt_shadow     = load_pend ? pend : shadow;

  // Bit selected for the upcoming slot (index unused outside shift slots).
  assign bit_idx = MSB_FIRST ? (SLOT_LASTB - nxt_slot) : nxt_slot;
  assign nxt_ds  = |(nxt_shadow & (CHAIN_BITS'(1) << bit_idx));

  // State, storage and registered pin outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      slot_cnt     <= '0;
      phase_cnt    <= '0;
      shadow       <= '0;
      pend         <= '0;
      pend_valid   <= 1'b0;
      latched_once <= 1'b0;
      din_ready    <= 1'b1;
      stcp         <= 1'b0;
      shcp         <= 1'b0;
      ds           <= 1'b0;
      oe           <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state      <= nxt_state;
      slot_cnt   <= nxt_slot;
      phase_cnt  <= nxt_phase;
      shadow     <= nxt_shadow;
      pend_valid <= nxt_pend_valid;
      if (accept) begin
        pend <= din;
      end
      if (frame_end) begin
        latched_once <= 1'b1;
      end
      din_ready  <= ~nxt_pend_valid;
      shcp       <= (nxt_state == ST_SHIFT) && (nxt_phase >= PH_HALF);
      stcp       <= (nxt_state == ST_LATCH) && (nxt_phase >= PH_HALF);
      if (nxt_state == ST_SHIFT) begin
        ds <= nxt_ds;
      end
      busy       <= (nxt_state != ST_IDLE);
      frame_done <= frame_end;
      // Blank until a full frame has been latched, so garbage never shows.
      oe         <= ~(oe_en & latched_once);
    end
  end

endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// Bench for hc595_chain_ctrl: two instances (defaults, and 16 bits / div 2 /
// MSB first) checked every cycle against a frame-offset reference model,
// plus directed literal checks for latency, bit order, oe and reset.
module tb_hc595_chain_ctrl;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  logic [13:0] din0 = '0;
  logic        din_valid0 = 0, auto0 = 0, oe_en0 = 1;
  logic        din_ready0, stcp0, shcp0, ds0, oe0, busy0, done0;

  logic [15:0] din1 = '0;
  logic        din_valid1 = 0, auto1 = 0, oe_en1 = 1;
  logic        din_ready1, stcp1, shcp1, ds1, oe1, busy1, done1;

  hc595_chain_ctrl #(.CHAIN_BITS(14), .CLK_DIV(4), .MSB_FIRST(1'b0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din0), .din_valid(din_valid0),
    .din_ready(din_ready0), .auto_refresh(auto0), .oe_en(oe_en0), .stcp(stcp0),
    .shcp(shcp0), .ds(ds0), .oe(oe0), .busy(busy0), .frame_done(done0)
  );

  hc595_chain_ctrl #(.CHAIN_BITS(16), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .auto_refresh(auto1), .oe_en(oe_en1), .stcp(stcp1),
    .shcp(shcp1), .ds(ds1), .oe(oe1), .busy(busy1), .frame_done(done1)
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
    end
  endtask

  // Reference model: a frame is a run of (N+1)*D cycles; outputs follow from
  // the cycle offset inside the frame (slot = off/D, phase = off%D).
  int          m_n [2] = '{14, 16};
  int          m_d [2] = '{4, 2};
  bit          m_m [2] = '{1'b0, 1'b1};
  bit          m_act[2], m_pv[2], m_done[2], m_latched[2], m_oe[2], m_ds[2];
  int          m_off[2];
  logic [63:0] m_frame[2], m_pend[2];

  task automatic model_reset(int i);
    m_act[i] = 0; m_pv[i] = 0; m_done[i] = 0; m_latched[i] = 0;
    m_oe[i] = 1; m_ds[i] = 0; m_off[i] = 0; m_frame[i] = '0; m_pend[i] = '0;
  endtask

  task automatic model_step(int i, bit v, logic [63:0] d, bit refr, bit oen);
    bit acc;
    int len;
    int slot;
    acc = v && !m_pv[i];
    len = (m_n[i] + 1) * m_d[i];
    m_oe[i]   = !(oen && m_latched[i]);
    m_done[i] = 0;
    if (!m_act[i]) begin
      if (m_pv[i]) begin
        m_act[i] = 1; m_off[i] = 0; m_frame[i] = m_pend[i]; m_pv[i] = 0;
      end
    end else if (m_off[i] == len - 1) begin
      m_done[i] = 1; m_latched[i] = 1;
      if (m_pv[i]) begin
        m_frame[i] = m_pend[i]; m_pv[i] = 0; m_off[i] = 0;
      end else if (refr) begin
        m_off[i] = 0;
      end else begin
        m_act[i] = 0;
      end
    end else begin
      m_off[i]++;
    end
    if (acc) begin
      m_pend[i] = d; m_pv[i] = 1;
    end
    slot = m_off[i] / m_d[i];
    if (m_act[i] && slot < m_n[i])
      m_ds[i] = m_frame[i][m_m[i] ? (m_n[i] - 1 - slot) : slot];
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, din_valid0, 64'(din0), auto0, oe_en0);
      model_step(1, din_valid1, 64'(din1), auto1, oe_en1);
    end
  end

  task automatic chk_inst(int i, logic rdy, logic st, logic sh, logic d,
                          logic o, logic b, logic fd);
    int  slot;
    int  ph;
    bit  half;
    slot = m_off[i] / m_d[i];
    ph   = m_off[i] % m_d[i];
    half = ph >= m_d[i] / 2;
    cmp($sformatf("u%0d.din_ready", i), 64'(rdy), 64'(!m_pv[i]));
    cmp($sformatf("u%0d.stcp", i), 64'(st), 64'(m_act[i] && slot == m_n[i] && half));
    cmp($sformatf("u%0d.shcp", i), 64'(sh), 64'(m_act[i] && slot < m_n[i] && half));
    cmp($sformatf("u%0d.ds", i), 64'(d), 64'(m_ds[i]));
    cmp($sformatf("u%0d.oe", i), 64'(o), 64'(m_oe[i]));
    cmp($sformatf("u%0d.busy", i), 64'(b), 64'(m_act[i]));
    cmp($sformatf("u%0d.frame_done", i), 64'(fd), 64'(m_done[i]));
  endtask

  always @(negedge sys_clk) begin
    chk_inst(0, din_ready0, stcp0, shcp0, ds0, oe0, busy0, done0);
    chk_inst(1, din_ready1, stcp1, shcp1, ds1, oe1, busy1, done1);
  end

  // Send one frame to an idle instance, then record the ds value at every
  // shcp rising edge and the cycle count from the accepting edge to frame_done.
  task automatic run_frame(int i, logic [63:0] d, int exp_n, int exp_edges,
                           logic [63:0] exp_cap);
    int          n;
    int          edges;
    bit          prev;
    bit          seen;
    bit          sh;
    logic [63:0] cap;
    @(negedge sys_clk); #1;
    if (i == 0) begin din0 = 14'(d); din_valid0 = 1; end
    else        begin din1 = 16'(d); din_valid1 = 1; end
    @(negedge sys_clk); #1;
    din_valid0 = 0; din_valid1 = 0;
    n = 0; edges = 0; prev = 0; seen = 0; cap = '0;
    while (!seen && n < 300) begin
      @(negedge sys_clk);
      n++;
      sh = (i == 0) ? shcp0 : shcp1;
      if (sh && !prev && edges < 64) begin
        cap[edges] = (i == 0) ? ds0 : ds1;
        edges++;
      end
      prev = sh;
      seen = (i == 0) ? done0 : done1;
    end
    cmp($sformatf("u%0d.latency", i), 64'(n), 64'(exp_n));
    cmp($sformatf("u%0d.edges", i), 64'(edges), 64'(exp_edges));
    cmp($sformatf("u%0d.ds_seq", i), cap, exp_cap);
  endtask

  task automatic wait_cycles(int k);
    repeat (k) @(negedge sys_clk);
  endtask

  initial begin : stim
    int dones;
    int n;
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1;
    wait_cycles(10);
    cmp("idle.din_ready", 64'(din_ready0), 64'd1);
    cmp("idle.oe", 64'(oe0), 64'd1);
    cmp("idle.busy", 64'(busy0), 64'd0);
    cmp("idle.stcp_shcp_ds", {61'd0, stcp0, shcp0, ds0}, 64'd0);

    // Bit 0 goes out first, so captured edge k holds din bit k.
    run_frame(0, 64'h2A5B, 61, 14, 64'h2A5B);
    cmp("u0.oe_at_done", 64'(oe0), 64'd1);
    @(negedge sys_clk);
    cmp("u0.oe_after_latch", 64'(oe0), 64'd0);

    // MSB first: edge k holds bit 15-k; 8001 reads 1,0...0,1.
    run_frame(1, 64'h8001, 35, 16, 64'h8001);
    wait_cycles(5);

    // Back-to-back: B offered during A's slot 3.
    @(negedge sys_clk); #1 din0 = 14'h1234; din_valid0 = 1;
    @(negedge sys_clk); #1 din_valid0 = 0;
    wait_cycles(14);
    #1 din0 = 14'h0ACE; din_valid0 = 1;
    @(negedge sys_clk); #1 din_valid0 = 0;
    cmp("b2b.ready_low", 64'(din_ready0), 64'd0);
    n = 0;
    while (!done0 && n < 200) begin @(negedge sys_clk); n++; end
    cmp("b2b.done_seen", 64'(done0), 64'd1);
    cmp("b2b.busy_no_gap", 64'(busy0), 64'd1);
    cmp("b2b.ready_back", 64'(din_ready0), 64'd1);
    wait_cycles(70);

    // Auto-refresh: frames every 60 cycles, then stop after dropping it.
    auto0 = 1;
    @(negedge sys_clk); #1 din0 = 14'h3FFF; din_valid0 = 1;
    @(negedge sys_clk); #1 din_valid0 = 0;
    dones = 0;
    repeat (185) begin @(negedge sys_clk); if (done0) dones++; end
    cmp("auto.done_count", 64'(dones), 64'd3);
    #1 auto0 = 0;
    wait_cycles(70);
    cmp("auto.stopped", 64'(busy0), 64'd0);

    // Reset in slot 7 with a frame pending.
    @(negedge sys_clk); #1 din0 = 14'h1555; din_valid0 = 1;
    @(negedge sys_clk); #1 din_valid0 = 0;
    wait_cycles(25);
    #1 din0 = 14'h2AAA; din_valid0 = 1;
    @(negedge sys_clk); #1 din_valid0 = 0;
    wait_cycles(3);
    #1 sys_rst_n = 0;
    #1;
    cmp("rst.async", {58'd0, stcp0, shcp0, ds0, busy0, oe0, din_ready0}, 64'h3);
    wait_cycles(2);
    #1 sys_rst_n = 1;
    wait_cycles(20);
    cmp("rst.oe_blanked", 64'(oe0), 64'd1);
    cmp("rst.pending_lost", 64'(busy0), 64'd0);

    // Randomized traffic on both instances.
    for (int c = 0; c < 4000; c++) begin
      @(negedge sys_clk); #1;
      din_valid0 = ($urandom_range(0, 3) == 0);
      din0       = 14'($urandom);
      din_valid1 = ($urandom_range(0, 3) == 0);
      din1       = 16'($urandom);
      if ($urandom_range(0, 199) == 0) auto0 = ~auto0;
      if ($urandom_range(0, 199) == 0) auto1 = ~auto1;
      if ($urandom_range(0, 99) == 0) oe_en0 = ~oe_en0;
      if ($urandom_range(0, 99) == 0) oe_en1 = ~oe_en1;
    end
    din_valid0 = 0; din_valid1 = 0;
    wait_cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
